// File: rtl/lab3_sequencer.sv
// Control sequencer for the Lab3 datapath: paces the 4-bit state code through load/compute/output.
// Define LAB3_SEQ_STEP_EN to add the i_step port and single-step the compute states.
module lab3_sequencer #(
  parameter int STATE_W = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic               i_out_ready,
  output logic               o_out_valid,
  output logic [STATE_W-1:0] o_state,
  output logic               o_wr_qual,
  output logic               o_busy,
  output logic               o_done,
  output logic [CNT_W-1:0]   o_run_cnt
`ifdef LAB3_SEQ_STEP_EN
  ,
  input  logic               i_step
`endif
);

  localparam logic [STATE_W-1:0] S_IDLE  = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_LOAD1 = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_LOAD4 = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_C5    = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_C11   = STATE_W'(11);
  localparam logic [STATE_W-1:0] S_OUT   = STATE_W'(12);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_next;
  logic               r_done;
  logic [CNT_W-1:0]   r_run_cnt;
  logic               w_is_load;
  logic               w_is_comp;
  logic               w_adv_comp;
  logic               w_handoff;

  assign w_is_load = (r_state >= S_LOAD1) && (r_state <= S_LOAD4);
  assign w_is_comp = (r_state >= S_C5) && (r_state <= S_C11);

`ifdef LAB3_SEQ_STEP_EN
  assign w_adv_comp = i_step;
`else
  assign w_adv_comp = 1'b1;
`endif

  // A completed handoff is the only event that produces done and bumps the run counter.
  assign w_handoff = (r_state == S_OUT) && i_out_ready && !i_abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_done    <= 1'b0;
      r_run_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_handoff;
      if (w_handoff) begin
        r_run_cnt <= r_run_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (i_abort) begin
      w_state_next = S_IDLE;
    end else if (r_state == S_IDLE) begin
      if (i_start) begin
        w_state_next = S_LOAD1;
      end
    end else if (w_is_load) begin
      if (i_in_valid) begin
        w_state_next = r_state + STATE_W'(1);
      end
    end else if (w_is_comp) begin
      if (w_adv_comp) begin
        w_state_next = r_state + STATE_W'(1);
      end
    end else if (r_state == S_OUT) begin
      if (i_out_ready) begin
        w_state_next = S_IDLE;
      end
    end else begin
      // Codes 13-15 are unreachable; recover to idle.
      w_state_next = S_IDLE;
    end
  end

  // A held state must never repeat a register-file write, so wr_qual follows the advance condition.
  always_comb begin
    o_in_ready  = w_is_load;
    o_out_valid = (r_state == S_OUT);
    o_busy      = (r_state != S_IDLE);
    o_wr_qual   = !i_abort && ((w_is_load && i_in_valid) || (w_is_comp && w_adv_comp));
  end

  assign o_state   = r_state;
  assign o_done    = r_done;
  assign o_run_cnt = r_run_cnt;

endmodule
